// File: rtl/param_counter.sv
// param_counter: general-purpose up/down event/timer counter.
//   - WIDTH-bit count over the range 0..MAX_VAL, reset value RST_VAL.
//   - Run modes: wrap (00, also 11), saturate (01), one-shot (10).
//   - Synchronous clear/load, registered terminal-count pulse, sticky ovf.
//   - Optional macro PARAM_COUNTER_GRAY_EN adds a registered gray_out port
//     that tracks out ^ (out >> 1) every cycle.
module param_counter #(
    parameter int               WIDTH   = 4,
    parameter logic [WIDTH-1:0] MAX_VAL = {WIDTH{1'b1}},
    parameter logic [WIDTH-1:0] RST_VAL = {WIDTH{1'b0}}
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             clr,
    input  logic             en,
    input  logic             up,
    input  logic [1:0]       mode,
    input  logic             start,
    input  logic             load,
    input  logic [WIDTH-1:0] load_val,
    output logic [WIDTH-1:0] out,
`ifdef PARAM_COUNTER_GRAY_EN
    output logic [WIDTH-1:0] gray_out,
`endif
    output logic             tc,
    output logic             ovf,
    output logic             busy
);

    localparam logic [1:0]     MODE_SAT     = 2'b01;
    localparam logic [1:0]     MODE_ONESHOT = 2'b10;
    localparam logic [WIDTH:0] MAX_EXT      = {1'b0, MAX_VAL};

    typedef enum logic [1:0] {
        ST_IDLE = 2'b00,
        ST_RUN  = 2'b01,
        ST_DONE = 2'b10
    } state_t;

    state_t           state_r;
    state_t           state_s;
    logic [WIDTH-1:0] cnt_r;
    logic [WIDTH-1:0] cnt_s;
    logic             tc_r;
    logic             tc_s;
    logic             ovf_r;
    logic             ovf_s;
    logic             busy_r;
    logic             busy_s;

    logic [WIDTH:0]   inc_s;
    logic [WIDTH:0]   dec_s;
    logic [WIDTH-1:0] step_s;
    logic [WIDTH-1:0] far_end_s;
    logic             at_term_s;

    // Loaded values above the legal range are pinned to MAX_VAL.
    function automatic logic [WIDTH-1:0] clamp_load(input logic [WIDTH-1:0] v);
        logic [WIDTH-1:0] r;
        if ({1'b0, v} > MAX_EXT) begin
            r = MAX_VAL;
        end else begin
            r = v;
        end
        return r;
    endfunction

`ifdef PARAM_COUNTER_GRAY_EN
    logic [WIDTH-1:0] gray_r;

    // Binary-reflected gray code of a count value.
    function automatic logic [WIDTH-1:0] to_gray(input logic [WIDTH-1:0] v);
        return v ^ (v >> 1);
    endfunction
`endif

    // Step arithmetic is one bit wider so carry/borrow exposes the range ends.
    always_comb begin
        inc_s = {1'b0, cnt_r} + {{WIDTH{1'b0}}, 1'b1};
        dec_s = {1'b0, cnt_r} - {{WIDTH{1'b0}}, 1'b1};
        if (up) begin
            at_term_s = (inc_s > MAX_EXT);
            step_s    = inc_s[WIDTH-1:0];
            far_end_s = {WIDTH{1'b0}};
        end else begin
            at_term_s = dec_s[WIDTH];
            step_s    = dec_s[WIDTH-1:0];
            far_end_s = MAX_VAL;
        end
    end

    // Next count, flags and one-shot state, applying clr > load > start > en.
    always_comb begin
        cnt_s = cnt_r;
        tc_s  = 1'b0;
        ovf_s = ovf_r;
        // Leaving one-shot mode parks the FSM in IDLE on the next edge.
        if (mode == MODE_ONESHOT) begin
            state_s = state_r;
        end else begin
            state_s = ST_IDLE;
        end

        if (clr) begin
            cnt_s   = {WIDTH{1'b0}};
            ovf_s   = 1'b0;
            state_s = ST_IDLE;
        end else if (load) begin
            cnt_s = clamp_load(load_val);
        end else if ((mode == MODE_ONESHOT) && start) begin
            // Launch or relaunch from the end opposite the terminal value.
            cnt_s   = far_end_s;
            state_s = ST_RUN;
        end else if (en) begin
            case (mode)
                MODE_SAT: begin
                    if (at_term_s) begin
                        tc_s  = 1'b1;
                        ovf_s = 1'b1;
                    end else begin
                        cnt_s = step_s;
                    end
                end
                MODE_ONESHOT: begin
                    case (state_r)
                        ST_RUN: begin
                            if (at_term_s) begin
                                tc_s    = 1'b1;
                                state_s = ST_DONE;
                            end else begin
                                cnt_s = step_s;
                            end
                        end
                        default: begin
                            // IDLE and DONE hold the count regardless of en.
                            cnt_s = cnt_r;
                        end
                    endcase
                end
                default: begin
                    // Wrap, and the reserved encoding that behaves as wrap.
                    if (at_term_s) begin
                        cnt_s = far_end_s;
                        tc_s  = 1'b1;
                        ovf_s = 1'b1;
                    end else begin
                        cnt_s = step_s;
                    end
                end
            endcase
        end else begin
            cnt_s = cnt_r;
        end

        busy_s = (state_s == ST_RUN);
    end

    // State and output registers with asynchronous reset.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt_r   <= RST_VAL;
            tc_r    <= 1'b0;
            ovf_r   <= 1'b0;
            busy_r  <= 1'b0;
            state_r <= ST_IDLE;
        end else begin
            cnt_r   <= cnt_s;
            tc_r    <= tc_s;
            ovf_r   <= ovf_s;
            busy_r  <= busy_s;
            state_r <= state_s;
        end
    end

`ifdef PARAM_COUNTER_GRAY_EN
    // Gray output registered from the same next value as the count.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            gray_r <= to_gray(RST_VAL);
        end else begin
            gray_r <= to_gray(cnt_s);
        end
    end

    assign gray_out = gray_r;
`endif

    assign out  = cnt_r;
    assign tc   = tc_r;
    assign ovf  = ovf_r;
    assign busy = busy_r;

endmodule

// File: tb/tb_param_counter.sv
// Self-checking bench for param_counter: a constant-expectation vector table
// on a MAX_VAL=9 instance, an asynchronous-reset sequence, and randomized
// stimulus on that instance plus a full-range (MAX_VAL=15, RST_VAL=5) one,
// both tracked by a behavioural reference model.
module tb_param_counter;

    localparam int W        = 4;
    localparam int PH_IDLE  = 0;
    localparam int PH_RUN   = 1;
    localparam int PH_DONE  = 2;

    logic         clk = 1'b0;
    logic         rst;
    logic         clr;
    logic         en;
    logic         up;
    logic [1:0]   mode;
    logic         start;
    logic         load;
    logic [W-1:0] load_val;

    logic [W-1:0] out_a;
    logic [W-1:0] out_b;
    logic         tc_a, ovf_a, busy_a;
    logic         tc_b, ovf_b, busy_b;
`ifdef PARAM_COUNTER_GRAY_EN
    logic [W-1:0] gray_a;
    logic [W-1:0] gray_b;
`endif

    int vectors     = 0;
    int miscompares = 0;

    typedef struct {
        int cnt;
        bit tc;
        bit ovf;
        int ph;
    } ref_t;

    typedef struct {
        bit    clr;
        bit    load;
        int    lv;
        bit    start;
        bit    en;
        bit    up;
        int    mode;
        int    e_out;
        bit    e_tc;
        bit    e_ovf;
        bit    e_busy;
        string name;
    } vec_t;

    ref_t ma;
    ref_t mb;
    vec_t vecs[$];

    always #5 clk = ~clk;

    param_counter #(.WIDTH(W), .MAX_VAL(4'd9), .RST_VAL(4'd0)) dut_a (
        .clk(clk), .rst(rst), .clr(clr), .en(en), .up(up), .mode(mode),
        .start(start), .load(load), .load_val(load_val), .out(out_a),
`ifdef PARAM_COUNTER_GRAY_EN
        .gray_out(gray_a),
`endif
        .tc(tc_a), .ovf(ovf_a), .busy(busy_a)
    );

    param_counter #(.WIDTH(W), .MAX_VAL(4'd15), .RST_VAL(4'd5)) dut_b (
        .clk(clk), .rst(rst), .clr(clr), .en(en), .up(up), .mode(mode),
        .start(start), .load(load), .load_val(load_val), .out(out_b),
`ifdef PARAM_COUNTER_GRAY_EN
        .gray_out(gray_b),
`endif
        .tc(tc_b), .ovf(ovf_b), .busy(busy_b)
    );

    // Reference model: one clock edge of the counter, written from the rules.
    function automatic ref_t model_step(ref_t s, int maxv, bit c, bit ld, int lv,
                                        bit st, bit e, bit u, int md);
        ref_t n;
        bit   oneshot;
        int   term;
        int   far_end;
        n       = s;
        n.tc    = 1'b0;
        oneshot = (md == 2);
        term    = u ? maxv : 0;
        far_end = u ? 0 : maxv;
        if (!oneshot) n.ph = PH_IDLE;
        if (c) begin
            n.cnt = 0;
            n.ovf = 1'b0;
            n.ph  = PH_IDLE;
        end else if (ld) begin
            n.cnt = (lv > maxv) ? maxv : lv;
        end else if (oneshot && st) begin
            n.ph  = PH_RUN;
            n.cnt = far_end;
        end else if (e) begin
            if (oneshot) begin
                if (s.ph == PH_RUN) begin
                    if (s.cnt == term) begin
                        n.ph = PH_DONE;
                        n.tc = 1'b1;
                    end else begin
                        n.cnt = s.cnt + (u ? 1 : -1);
                    end
                end
            end else if (s.cnt == term) begin
                n.tc  = 1'b1;
                n.ovf = 1'b1;
                if (md != 1) n.cnt = far_end;
            end else begin
                n.cnt = s.cnt + (u ? 1 : -1);
            end
        end
        return n;
    endfunction

    function automatic ref_t model_reset(int rv);
        ref_t r;
        r.cnt = rv;
        r.tc  = 1'b0;
        r.ovf = 1'b0;
        r.ph  = PH_IDLE;
        return r;
    endfunction

    task automatic cmp(string name, int act, int exp);
        vectors++;
        if (act != exp) begin
            miscompares++;
            $display("FAIL %s: got %0d, expected %0d", name, act, exp);
        end
    endtask

    task automatic check_models(string tag);
        cmp({tag, " a.out"},  int'(out_a),  ma.cnt);
        cmp({tag, " a.tc"},   int'(tc_a),   int'(ma.tc));
        cmp({tag, " a.ovf"},  int'(ovf_a),  int'(ma.ovf));
        cmp({tag, " a.busy"}, int'(busy_a), (ma.ph == PH_RUN) ? 1 : 0);
        cmp({tag, " b.out"},  int'(out_b),  mb.cnt);
        cmp({tag, " b.tc"},   int'(tc_b),   int'(mb.tc));
        cmp({tag, " b.ovf"},  int'(ovf_b),  int'(mb.ovf));
        cmp({tag, " b.busy"}, int'(busy_b), (mb.ph == PH_RUN) ? 1 : 0);
`ifdef PARAM_COUNTER_GRAY_EN
        cmp({tag, " a.gray"}, int'(gray_a), ma.cnt ^ (ma.cnt >> 1));
        cmp({tag, " b.gray"}, int'(gray_b), mb.cnt ^ (mb.cnt >> 1));
`endif
    endtask

    // Advance both models and the DUTs by one edge; sample 1 ns later.
    task automatic step();
        ref_t na;
        ref_t nb;
        na = model_step(ma, 9,  clr, load, int'(load_val), start, en, up, int'(mode));
        nb = model_step(mb, 15, clr, load, int'(load_val), start, en, up, int'(mode));
        @(posedge clk);
        #1;
        ma = na;
        mb = nb;
    endtask

    task automatic drive(bit c, bit ld, int lv, bit st, bit e, bit u, int md);
        clr      = c;
        load     = ld;
        load_val = W'(lv);
        start    = st;
        en       = e;
        up       = u;
        mode     = 2'(md);
    endtask

    function automatic vec_t mk(bit c, bit ld, int lv, bit st, bit e, bit u, int md,
                                int eo, bit et, bit eov, bit eb, string nm);
        vec_t v;
        v.clr = c;  v.load = ld; v.lv = lv; v.start = st; v.en = e; v.up = u;
        v.mode = md; v.e_out = eo; v.e_tc = et; v.e_ovf = eov; v.e_busy = eb;
        v.name = nm;
        return v;
    endfunction

    initial begin
        // Expected behaviour of the MAX_VAL=9 instance, one row per edge.
        for (int k = 1; k <= 9; k++) vecs.push_back(mk(0,0,0,0,1,1,0, k,0,0,0, "wrap_up"));
        vecs.push_back(mk(0,0,0,0,1,1,0, 0,1,1,0, "wrap_9to0"));
        vecs.push_back(mk(0,0,0,0,1,1,0, 1,0,1,0, "wrap_after"));
        vecs.push_back(mk(1,0,0,0,0,0,1, 0,0,0,0, "clr_ovf"));
        vecs.push_back(mk(0,1,2,0,0,0,1, 2,0,0,0, "sat_load2"));
        vecs.push_back(mk(0,0,0,0,1,0,1, 1,0,0,0, "sat_dn1"));
        vecs.push_back(mk(0,0,0,0,1,0,1, 0,0,0,0, "sat_dn0"));
        vecs.push_back(mk(0,0,0,0,1,0,1, 0,1,1,0, "sat_hold1"));
        vecs.push_back(mk(0,0,0,0,1,0,1, 0,1,1,0, "sat_hold2"));
        vecs.push_back(mk(0,0,0,0,1,0,1, 0,1,1,0, "sat_hold3"));
        vecs.push_back(mk(1,0,0,0,0,0,1, 0,0,0,0, "sat_clr"));
        vecs.push_back(mk(0,0,0,0,1,1,2, 0,0,0,0, "os_idle_hold"));
        vecs.push_back(mk(0,0,0,1,1,1,2, 0,0,0,1, "os_start"));
        for (int k = 1; k <= 9; k++) vecs.push_back(mk(0,0,0,0,1,1,2, k,0,0,1, "os_run"));
        vecs.push_back(mk(0,0,0,0,1,1,2, 9,1,0,0, "os_done"));
        vecs.push_back(mk(0,0,0,0,1,1,2, 9,0,0,0, "os_done_hold"));
        vecs.push_back(mk(0,0,0,1,0,1,2, 0,0,0,1, "os_restart"));
        vecs.push_back(mk(0,0,0,0,1,1,2, 1,0,0,1, "os_run2"));
        vecs.push_back(mk(0,1,15,0,0,1,2, 9,0,0,1, "load_clamp"));
        vecs.push_back(mk(1,1,3,0,1,1,2, 0,0,0,0, "clr_load_en"));
        vecs.push_back(mk(0,0,0,0,1,0,0, 9,1,1,0, "wrap_0to9"));
        vecs.push_back(mk(0,0,0,0,1,0,0, 8,0,1,0, "wrap_dn"));
        vecs.push_back(mk(0,0,0,1,0,1,2, 0,0,1,1, "os_start2"));
        vecs.push_back(mk(0,0,0,0,0,1,0, 0,0,1,0, "mode_leave"));
        vecs.push_back(mk(0,0,0,0,1,1,0, 1,0,1,0, "dir_up"));
        vecs.push_back(mk(0,0,0,0,1,0,0, 0,0,1,0, "dir_dn"));
        vecs.push_back(mk(0,0,0,0,1,0,0, 9,1,1,0, "dir_wrap"));

        // Reset state.
        rst = 1'b1;
        drive(0, 0, 0, 0, 0, 1, 0);
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;
        ma  = model_reset(0);
        mb  = model_reset(5);
        cmp("reset a.out",  int'(out_a),  0);
        cmp("reset b.out",  int'(out_b),  5);
        cmp("reset a.tc",   int'(tc_a),   0);
        cmp("reset a.ovf",  int'(ovf_a),  0);
        cmp("reset a.busy", int'(busy_a), 0);
`ifdef PARAM_COUNTER_GRAY_EN
        cmp("reset b.gray", int'(gray_b), 7);
`endif
        check_models("reset");

        // Table-driven vectors.
        foreach (vecs[i]) begin
            drive(vecs[i].clr, vecs[i].load, vecs[i].lv, vecs[i].start,
                  vecs[i].en, vecs[i].up, vecs[i].mode);
            step();
            cmp({vecs[i].name, " out"},  int'(out_a),  vecs[i].e_out);
            cmp({vecs[i].name, " tc"},   int'(tc_a),   int'(vecs[i].e_tc));
            cmp({vecs[i].name, " ovf"},  int'(ovf_a),  int'(vecs[i].e_ovf));
            cmp({vecs[i].name, " busy"}, int'(busy_a), int'(vecs[i].e_busy));
            check_models(vecs[i].name);
        end

        // Asynchronous reset in the middle of a one-shot run (ovf still set).
        drive(0, 1, 0, 0, 0, 1, 2);
        step();
        check_models("ar_load");
        drive(0, 0, 0, 1, 0, 1, 2);
        step();
        check_models("ar_start");
        drive(0, 0, 0, 0, 1, 1, 2);
        repeat (6) begin
            step();
            check_models("ar_run");
        end
        cmp("ar pre out",  int'(out_a),  6);
        cmp("ar pre busy", int'(busy_a), 1);
        cmp("ar pre ovf",  int'(ovf_a),  1);
        @(negedge clk);
        #2;
        rst = 1'b1;
        #1;
        cmp("ar now out",  int'(out_a),  0);
        cmp("ar now busy", int'(busy_a), 0);
        cmp("ar now tc",   int'(tc_a),   0);
        cmp("ar now ovf",  int'(ovf_a),  0);
        cmp("ar now b.out", int'(out_b), 5);
        drive(0, 0, 0, 0, 0, 1, 0);
        @(posedge clk);
        #1;
        rst = 1'b0;
        ma  = model_reset(0);
        mb  = model_reset(5);
        check_models("ar_after");

        // Randomized stimulus against the reference model.
        for (int n = 0; n < 600; n++) begin
            drive(($urandom_range(15) == 0),
                  ($urandom_range(7) == 0),
                  int'($urandom_range(15)),
                  ($urandom_range(7) == 0),
                  ($urandom_range(3) != 0),
                  ($urandom_range(9) < 7),
                  int'($urandom_range(3)));
            step();
            check_models("rnd");
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
